// File: rtl/adc_frame_trigger.sv
// Pre/post-trigger capture of packed 8-bit ADC samples into a ring buffer, then
// replay of one FRAME_WORDS-word frame around the trigger word on an AXI-Stream master.
module adc_frame_trigger #(
    parameter int         FRAME_WORDS = 256,
    parameter int         PRE_WORDS   = 16,
    parameter logic [7:0] THRESHOLD   = 8'h80
) (
    input  logic        clkin,
    input  logic        rstn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic        arm,
    input  logic        force_trig,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] drop_cnt
);
    localparam int              AW        = $clog2(FRAME_WORDS);
    localparam logic [AW-1:0]   PRE_W     = AW'(PRE_WORDS);
    localparam logic [AW-1:0]   POST_INIT = AW'(FRAME_WORDS - PRE_WORDS - 1);
    localparam logic [AW-1:0]   ONE_W     = AW'(1);
    localparam logic [AW:0]     FRAME_CNT = (AW+1)'(FRAME_WORDS);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DRAIN} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [31:0]    r_ring [FRAME_WORDS];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_out_cnt;
    logic [AW-1:0]  r_pre_cnt;
    logic [AW-1:0]  r_post_cnt;
    logic [7:0]     r_prev_byte;
    logic           r_force;
    logic [15:0]    r_drop_cnt;
    logic [31:0]    r_m_tdata;
    logic           r_m_tvalid;
    logic           r_m_tlast;
    logic           r_frame_done;

    logic w_acc;
    logic w_cross;
    logic w_trig;
    logic w_pre_done;
    logic w_post_done;
    logic w_out_hs;
    logic w_frame_end;
    logic w_issue;

    // Rising-edge test over the four samples, oldest first, chained from the previous word.
    function automatic logic has_crossing(input logic [7:0] prev, input logic [31:0] word);
        logic [7:0] p;
        logic       hit;
        p   = prev;
        hit = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if ((p < THRESHOLD) && (word[i*8 +: 8] >= THRESHOLD)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
            p = word[i*8 +: 8];
        end
        return hit;
    endfunction

    assign w_acc       = s_axis_tvalid && s_axis_tready;
    assign w_cross     = has_crossing(r_prev_byte, s_axis_tdata);
    assign w_trig      = (r_state == ARMED) && w_acc && (w_cross || r_force || force_trig);
    assign w_pre_done  = (r_state == PRE) && w_acc && (r_pre_cnt == (PRE_W - ONE_W));
    assign w_post_done = (r_state == POST) && w_acc && (r_post_cnt == ONE_W);
    assign w_out_hs    = r_m_tvalid && m_axis_tready;
    assign w_frame_end = (r_state == DRAIN) && w_out_hs && r_m_tlast;
    assign w_issue     = (r_state == DRAIN) && (r_out_cnt != FRAME_CNT) && (!r_m_tvalid || m_axis_tready);

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign frame_done    = r_frame_done;
    assign drop_cnt      = r_drop_cnt;

    // State register.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (arm)         w_next_state = PRE;   else w_next_state = IDLE;
            PRE:     if (w_pre_done)  w_next_state = ARMED; else w_next_state = PRE;
            ARMED:   if (w_trig)      w_next_state = (POST_INIT == '0) ? DRAIN : POST;
                     else             w_next_state = ARMED;
            POST:    if (w_post_done) w_next_state = DRAIN; else w_next_state = POST;
            DRAIN:   if (w_frame_end) w_next_state = IDLE;  else w_next_state = DRAIN;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        s_axis_tready = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE:             begin s_axis_tready = 1'b0; busy = 1'b0; end
            PRE, ARMED, POST: begin s_axis_tready = 1'b1; busy = 1'b1; end
            DRAIN:            begin s_axis_tready = 1'b0; busy = 1'b1; end
            default:          begin s_axis_tready = 1'b0; busy = 1'b1; end
        endcase
    end

    // Ring storage; contents are don't-care until written.
    always_ff @(posedge clkin) begin
        if (w_acc) begin
            r_ring[r_wr_ptr] <= s_axis_tdata;
        end
    end

    // Capture-side bookkeeping: write pointer, counters, trigger history, drop counter.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_prev_byte <= 8'hFF;
            r_force     <= 1'b0;
            r_drop_cnt  <= 16'h0000;
        end else begin
            if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE_W;
            end
            if ((r_state == DRAIN) && s_axis_tvalid && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'h0001;
            end
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_pre_cnt   <= '0;
                        r_prev_byte <= 8'hFF;
                    end
                end
                PRE: begin
                    if (w_acc) begin
                        r_pre_cnt   <= r_pre_cnt + ONE_W;
                        r_prev_byte <= s_axis_tdata[7:0];
                    end
                end
                ARMED: begin
                    if (w_acc) begin
                        r_prev_byte <= s_axis_tdata[7:0];
                    end
                    if (w_trig) begin
                        r_force    <= 1'b0;
                        r_post_cnt <= POST_INIT;
                    end else if (force_trig) begin
                        r_force <= 1'b1;
                    end
                end
                POST: begin
                    if (w_acc) begin
                        r_post_cnt <= r_post_cnt - ONE_W;
                    end
                end
                DRAIN: begin
                    r_post_cnt <= r_post_cnt;
                end
                default: begin
                    r_force <= 1'b0;
                end
            endcase
        end
    end

    // Replay: the trigger word's address sets the frame start; one registered word per handshake.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr     <= '0;
            r_out_cnt    <= '0;
            r_m_tdata    <= 32'h0000_0000;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_trig) begin
                r_rd_ptr  <= r_wr_ptr - PRE_W;
                r_out_cnt <= '0;
            end else if (w_issue) begin
                r_m_tdata  <= r_ring[r_rd_ptr];
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= (r_out_cnt == (FRAME_CNT - 1'b1));
                r_rd_ptr   <= r_rd_ptr + ONE_W;
                r_out_cnt  <= r_out_cnt + 1'b1;
            end else if (w_out_hs) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_trigger.sv
// Directed bench for adc_frame_trigger with FRAME_WORDS=16, PRE_WORDS=4, THRESHOLD=8'h80.
module tb_adc_frame_trigger;
    localparam int FW = 16;
    localparam int PW = 4;

    logic        clkin = 1'b0;
    logic        rstn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        arm;
    logic        force_trig;
    logic        busy;
    logic        frame_done;
    logic [15:0] drop_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] stim [0:31];

    adc_frame_trigger #(.FRAME_WORDS(FW), .PRE_WORDS(PW), .THRESHOLD(8'h80)) dut (
        .clkin(clkin), .rstn(rstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .arm(arm), .force_trig(force_trig), .busy(busy),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic do_reset();
        rstn = 1'b0; s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        arm = 1'b0; force_trig = 1'b0;
        repeat (3) @(negedge clkin);
        rstn = 1'b1;
        @(negedge clkin);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clkin);
        arm = 1'b0;
    endtask

    // Drives stim[0..n-1], one word per cycle; optional force pulse on a word, an idle
    // force-only cycle before word gap_before, and a stray arm pulse on word arm_at.
    task automatic feed(input int n, input int force_same, input int gap_before, input int arm_at,
                        output int not_ready);
        not_ready = 0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_before) begin
                s_axis_tvalid = 1'b0; force_trig = 1'b1;
                @(negedge clkin);
            end
            s_axis_tdata  = stim[i];
            s_axis_tvalid = 1'b1;
            force_trig    = (i == force_same);
            arm           = (i == arm_at);
            if (s_axis_tready !== 1'b1) not_ready++;
            @(negedge clkin);
        end
        s_axis_tvalid = 1'b0; force_trig = 1'b0; arm = 1'b0;
    endtask

    // Consumes n_hs output words expecting stim[t-PW ..], checking order, tlast, stall stability.
    task automatic collect(input int t, input int n_hs, input bit rnd, input string name);
        int idx = 0; int cyc = 0; int first = 0; int t_first = -1; int t_last = 0; int unstable = 0;
        bit stalled = 1'b0; logic [31:0] hd = 32'h0; logic hl = 1'b0; logic exp_last;
        while (idx < n_hs && cyc < 500) begin
            cyc++;
            if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tlast !== hl)) unstable++;
            if (m_axis_tvalid === 1'b1 && first == 0) first = cyc;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                exp_last = (idx == FW - 1);
                checks++;
                if (m_axis_tdata !== stim[t - PW + idx] || m_axis_tlast !== exp_last) begin
                    failures++;
                    $display("FAIL %s word%0d: got data=%h last=%b, expected data=%h last=%b",
                             name, idx, m_axis_tdata, m_axis_tlast, stim[t - PW + idx], exp_last);
                end
                if (t_first < 0) t_first = cyc;
                t_last = cyc; idx++; stalled = 1'b0;
            end else begin
                stalled = (m_axis_tvalid === 1'b1); hd = m_axis_tdata; hl = m_axis_tlast;
            end
            @(negedge clkin);
        end
        checks++;
        if (idx != n_hs) begin failures++; $display("FAIL %s count: got %0d words, expected %0d", name, idx, n_hs); end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL %s stall_stable: got %0d changes, expected 0", name, unstable); end
        if (!rnd) begin
            checks++;
            if (first > 3 || first == 0) begin failures++; $display("FAIL %s latency: first valid at cycle %0d, expected <=3", name, first); end
            checks++;
            if (t_last - t_first != n_hs - 1) begin failures++; $display("FAIL %s throughput: span %0d, expected %0d", name, t_last - t_first, n_hs - 1); end
        end
        if (n_hs == FW) begin
            checks++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b1) begin
                failures++;
                $display("FAIL %s end: got tvalid=%b busy=%b done=%b, expected 0 0 1", name, m_axis_tvalid, busy, frame_done);
            end
            @(negedge clkin);
            checks++;
            if (frame_done !== 1'b0) begin failures++; $display("FAIL %s done_pulse: got %b, expected 0", name, frame_done); end
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic load_edge_stim();
        for (int k = 0; k < 22; k++) stim[k] = 32'(32'h01010101 * k);
        stim[10] = 32'h102090A0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b, expected 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 32'h0) begin failures++; $display("FAIL rst_tdata: got %h, expected 0", m_axis_tdata); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b, expected 0", frame_done); end
        checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b, expected 0", s_axis_tready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL rst_drop: got %h, expected 0", drop_cnt); end
    endtask

    task automatic test_edge_trigger();
        int nr;
        load_edge_stim();
        do_arm();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL edge_busy: got %b, expected 1", busy); end
        feed(22, 2, -1, 6, nr);
        checks++; if (nr != 0) begin failures++; $display("FAIL edge_accept: got %0d refused, expected 0", nr); end
        collect(10, FW, 1'b0, "edge");
    endtask

    task automatic test_boundary();
        int nr;
        for (int k = 0; k < 22; k++) stim[k] = 32'h10101000 | 32'(k);
        stim[3]  = 32'h1000FF10;
        stim[9]  = 32'h1010107F;
        stim[10] = 32'h80101010;
        do_arm();
        feed(22, -1, -1, -1, nr);
        checks++; if (nr != 0) begin failures++; $display("FAIL bnd_accept: got %0d refused, expected 0", nr); end
        collect(10, FW, 1'b0, "boundary");
    endtask

    task automatic test_force();
        int nr;
        for (int k = 0; k < 20; k++) stim[k] = 32'h10101000 | 32'(k + 1);
        do_arm();
        feed(20, -1, 8, -1, nr);
        checks++; if (nr != 0) begin failures++; $display("FAIL force_accept: got %0d refused, expected 0", nr); end
        collect(8, FW, 1'b0, "force");
        do_arm();
        feed(18, 6, -1, -1, nr);
        collect(6, FW, 1'b0, "force_same");
    endtask

    task automatic test_back_to_back();
        int nr;
        load_edge_stim();
        for (int f = 0; f < 3; f++) begin
            do_arm();
            feed(22, -1, -1, -1, nr);
            collect(10, FW, 1'b1, "backpressure");
        end
    endtask

    task automatic test_drop();
        int nr;
        load_edge_stim();
        do_arm();
        feed(22, -1, -1, -1, nr);
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
        repeat (5) @(negedge clkin);
        s_axis_tvalid = 1'b0;
        checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL drop5: got %0d, expected 5", drop_cnt); end
        checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL drop_tready: got %b, expected 0", s_axis_tready); end
        s_axis_tvalid = 1'b1;
        repeat (65529) @(negedge clkin);
        s_axis_tvalid = 1'b0;
        checks++; if (drop_cnt !== 16'hFFFE) begin failures++; $display("FAIL drop_fffe: got %h, expected fffe", drop_cnt); end
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clkin);
        s_axis_tvalid = 1'b0;
        checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL drop_sat: got %h, expected ffff", drop_cnt); end
        collect(10, FW, 1'b0, "drop_frame");
    endtask

    task automatic test_reset_mid();
        int nr;
        load_edge_stim();
        do_arm();
        feed(22, -1, -1, -1, nr);
        collect(10, 7, 1'b0, "mid_part");
        #1 rstn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b, expected 0", m_axis_tvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL mid_drop: got %h, expected 0", drop_cnt); end
        @(negedge clkin);
        rstn = 1'b1;
        @(negedge clkin);
        do_arm();
        feed(22, -1, -1, -1, nr);
        collect(10, FW, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_edge_trigger();
        test_boundary();
        test_force();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_frame_trigger.md
ADC_FRAME_TRIGGER -- requirements
Module: adc_frame_trigger

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 256, meaning 32-bit words per output frame; power of two, 8..4096.
REQ-002 SHALL have parameter PRE_WORDS, default 16, meaning words kept ahead of the trigger word; 1..FRAME_WORDS-2.
REQ-003 SHALL have parameter THRESHOLD, default 8'h80, meaning the unsigned 8-bit level for rising-edge trigger.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clkin and rstn.
REQ-005 Ports SHALL be:
- clkin  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  32  four packed 8-bit samples; [31:24] oldest, [7:0] newest.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word accepted when high with tvalid.
- m_axis_tdata  out  32  frame word.
- m_axis_tvalid  out  1  frame word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of frame.
- arm  in  1  one-cycle pulse that starts a capture.
- force_trig  in  1  one-cycle pulse for a software trigger.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last output handshake.
- drop_cnt  out  16  saturating count of words refused in DRAIN.

Function
REQ-006 The FSM SHALL have states IDLE, PRE, ARMED, POST and DRAIN.
REQ-007 An accepted word SHALL be one where s_axis_tvalid and s_axis_tready are both high.
REQ-008 s_axis_tready SHALL be 1 in PRE, ARMED and POST, and 0 in IDLE and DRAIN.
REQ-009 Storage SHALL be a ring of FRAME_WORDS x 32 bits; every accepted word is written at wr_ptr, then wr_ptr increments modulo FRAME_WORDS.
REQ-010 IDLE transitions:
- arm goes to PRE.
- On that transition, pre_cnt is cleared and prev_byte is set to 8'hFF.
- arm outside IDLE SHALL be ignored.
REQ-011 PRE SHALL count accepted words and go to ARMED on the accepted word that makes pre_cnt equal PRE_WORDS.
- No triggers are evaluated in PRE.
- force_trig in PRE SHALL be ignored.
REQ-012 Crossing test: each byte is checked in order [31:24], [23:16], [15:8], [7:0] against its predecessor.
- The predecessor of byte [31:24] is prev_byte.
- A crossing is predecessor < THRESHOLD and byte >= THRESHOLD, both unsigned.
REQ-013 prev_byte SHALL update to byte [7:0] of every accepted word in PRE and ARMED.
REQ-014 Trigger word in ARMED: the first accepted word that contains a crossing, or the first accepted word after force_trig is latched.
- The force_trig latch is set only in ARMED and cleared on trigger or reset.
- A force_trig on the same cycle as an accepted word SHALL make that word the trigger word.
REQ-015 On the trigger word:
- Record trig_addr as the address written.
- Set post_cnt = FRAME_WORDS-PRE_WORDS-1.
- Go to POST, or go directly to DRAIN if post_cnt = 0.
REQ-016 POST SHALL decrement post_cnt per accepted word and go to DRAIN on the word that brings it to 0.
REQ-017 DRAIN SHALL output FRAME_WORDS words starting at (trig_addr-PRE_WORDS) mod FRAME_WORDS, in address order.
- The frame is PRE_WORDS pre-trigger words, then the trigger word, then the post words.
REQ-018 First m_axis_tvalid SHALL assert no later than 2 cycles after entering DRAIN.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable.
- m_axis_tvalid SHALL NOT drop until the handshake completes.
REQ-020 On full throughput (m_axis_tready held 1), DRAIN SHALL output one word per cycle after the first.
REQ-021 m_axis_tlast SHALL be 1 exactly on word FRAME_WORDS of the frame.
REQ-022 End of frame: on the last handshake, m_axis_tvalid is 0 the next cycle, the state is IDLE, and frame_done pulses for 1 cycle.
REQ-023 drop_cnt SHALL increment by 1 per cycle in DRAIN with s_axis_tvalid=1, and saturate at 16'hFFFF.
- drop_cnt is cleared only by reset.
REQ-024 busy SHALL be combinational, equal to (state != IDLE).

Reset
REQ-025 rstn=0 SHALL asynchronously clear all state. Reset values:
- state=IDLE, wr_ptr=0, pre_cnt=0, post_cnt=0, force latch=0, prev_byte=8'hFF, drop_cnt=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0, s_axis_tready=0.
REQ-026 Reset asserted mid-frame in any state SHALL abandon the frame; no partial tlast is emitted.
REQ-027 Ring contents SHALL NOT need reset.

Verification
(Use FRAME_WORDS=16, PRE_WORDS=4, THRESHOLD=8'h80 unless stated.)
REQ-028 Edge trigger: arm; feed words W0..W9 = 32'h01010101*k, all bytes < 8'h80; then W10=32'h102090A0; then W11..W21.
- Required response: the frame is W6..W9, W10, W11..W21 (16 words), tlast on W21, frame_done 1 cycle after.
REQ-029 Boundary crossing: W9 [7:0]=8'h7F and W10 [31:24]=8'h80 -> W10 is the trigger word.
- W3 containing 8'h00->8'hFF while in PRE -> no trigger.
REQ-030 Force trigger: arm, feed 20 words all 8'h10, pulse force_trig after word 8 is accepted.
- Required response: word 9 is the trigger word; frame = words 5..20.
REQ-031 Backpressure: random m_axis_tready (50%) across 3 frames -> word order identical to the tready=1 case, no duplicates or gaps, tdata stable while stalled.
REQ-032 Drop: 5 valid input words arriving during DRAIN -> drop_cnt=5, s_axis_tready=0.
- Preloaded at 16'hFFFE, 3 more drops -> drop_cnt=16'hFFFF.
REQ-033 Reset mid-DRAIN after 7 handshakes -> m_axis_tvalid=0 immediately, busy=0, drop_cnt=0.
- A new arm then captures a correct 16-word frame.
